hash_jitter_pipe: RTL and testbench
===================================

// Module: hash_jitter_pipe
// PURPOSE
//  Parametrised successor of the rasterizer jitter-hash stage. Sits between sample
//  generation and the sample test. For each of SAMPS sample lanes it XOR-tree hashes
//  the sample coordinates and a per-frame seed into an x/y jitter offset, then ORs the
//  offset into the fractional sample bits. It carries triangle/colour sideband through
//  a PIPE_DEPTH-deep elastic pipeline with valid/ready backpressure.
// PARAMETERS
//  SIGFIG      24  fixed-point word width
//  RADIX       10  fractional bits
//  VERTS        3  triangle vertices
//  AXIS         3  coords per vertex
//  COLORS       3  colour channels
//  SAMPS        4  sample lanes per beat (>=1)
//  PIPE_DEPTH   2  pipeline stages (>=1), latency in cycles
//  SEED_W      16  width of the frame seed
// PORTS
//  clk               in   1                    clock
//  rst               in   1                    asynchronous, active-low reset
//  in_valid_R14H     in   1                    input beat valid
//  in_ready_R14H     out  1                    stage accepts a beat
//  tri_R14S          in   SIGFIG[VERTS][AXIS]  triangle
//  color_R14U        in   SIGFIG[COLORS]       colour
//  sample_R14S       in   SIGFIG[2][SAMPS]     sample x/y per lane
//  validSamp_R14H    in   1[SAMPS]             per-lane valid mask
//  subSample_RnnnnU  in   4                    one-hot MSAA select (quasi-static)
//  jitter_en_RnnnnH  in   1                    0: samples pass unmodified
//  seed_RnnnnU       in   SEED_W               frame seed, sampled with each beat
//  out_valid_R16H    out  1                    output beat valid
//  out_ready_R16H    in   1                    downstream accepts
//  tri_R16S, color_R16U, sample_R16S, validSamp_R16H  out  same as inputs
//  cfg_err_RnnnnH    out  1                    sticky: non-one-hot subSample seen
// BEHAVIOUR
//  - Reset (rst=0, async): all stage-valid bits=0, out_valid=0, cfg_err=0, all data
//    outputs=0, validSamp_R16H all 0. Deassertion is synchronised by the parent.
//  - Handshake: a beat transfers on a rising edge when valid&&ready on that side.
//    in_ready = !stage0_valid || stage0_advances. Stage k advances when it is valid
//    and (stage k+1 is empty or advancing). The last stage advances on out_ready.
//    Bubbles collapse. out_valid must not drop and data must not change while
//    out_valid && !out_ready.
//  - Latency PIPE_DEPTH cycles with no stall. Full throughput of 1 beat/cycle.
//    No combinational path from out_ready to in_ready beyond the per-stage advance
//    chain.
//  - Hash runs in stage 0 (combinational on the R14 inputs). Result is registered
//    with the beat.
//    HIN=2*(SIGFIG-4)+SEED_W, HOUT=RADIX-2.
//    x input = {y[SIGFIG-1:4], x[SIGFIG-1:4], seed}
//    y input = {x[SIGFIG-1:4], y[SIGFIG-1:4], ~seed}
//  - Mask from subSample: [3]=8'hFF, [2]=8'h7F, [1]=8'h3F, [0]=8'h1F (HOUT=8 case,
//    generally right-shifted ones). Non-one-hot value: mask=all-ones (MSAA=1),
//    cfg_err set and held until reset.
//  - Jitter: sample_out = sample_in | (jit << (RADIX-HOUT)). Bits >= RADIX and bits
//    < RADIX-HOUT pass unchanged. jitter_en=0 or lane invalid: lane sample passes
//    unmodified.
//  - validSamp lanes are carried as data. A beat with in_valid=1 and all lanes 0 is
//    still transferred.
//  - seed/subSample/jitter_en are sampled only at beat acceptance. A mid-flight
//    change does not affect accepted beats.
//  - Reset mid-operation: in-flight beats are discarded, with no output transfer
//    after reset.
// STRUCTURE
//  - Shared package rast_pkg: SIGFIG/RADIX/SAMPS defaults, typedef sample_t
//    (logic signed [SIGFIG-1:0]), typedef samp_vec_t, function msaa_mask(subSample)
//    returning the HOUT mask.
//  - Sub-modules: existing tree_hash (x2 per lane in a generate loop over
//    0..SAMPS-1) and one new elastic_stage (payload width param, valid/ready,
//    async active-low reset) instantiated PIPE_DEPTH times on a packed payload.
//  - No retiming-register split. All stages are fixed flops.
// TESTING
//  1 Reset: hold rst=0, toggle in_valid -> out_valid=0, in_ready=1 after release,
//    cfg_err=0.
//  2 Streaming, PIPE_DEPTH=2, out_ready=1, 10 beats, subSample=4'b1000,
//    jitter_en=0 -> 10 beats out 2 cycles later, samples bit-exact to inputs.
//  3 Jitter check: x=24'h000400, y=24'h000C00, seed=16'h1234, subSample=4'b0100 ->
//    output equals reference-model tree hash with mask 8'h7F placed at bits [9:2].
//    Bits [1:0] and [23:10] unchanged.
//  4 Backpressure: out_ready=0 for 5 cycles during a stream -> in_ready falls after
//    PIPE_DEPTH beats, out data stable. On release, no loss or duplication, order
//    preserved.
//  5 Config error: subSample=4'b0110 -> cfg_err=1 and stays 1 after a legal value.
//    Jitter uses mask 8'hFF.
//  6 Mid-flight reset: assert rst=0 with 2 beats in flight -> outputs 0
//    immediately. After release, no stale beat emerges.

Source files
------------

// File: rtl/rast_pkg.sv
// Shared rasterizer definitions: default word geometry, sample types and the
// MSAA-dependent jitter mask.
package rast_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int SAMPS  = 4;
    localparam int HOUT   = RADIX - 2;

    typedef logic signed [SIGFIG-1:0] sample_t;
    typedef sample_t [SAMPS-1:0]      samp_vec_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Fewer MSAA samples get a narrower jitter; an illegal select falls back to full width.
    function automatic logic [HOUT-1:0] msaa_mask(input logic [3:0] sub);
        logic [HOUT-1:0] ones;
        ones = '1;
        case (sub)
            4'b1000: return ones;
            4'b0100: return ones >> 1;
            4'b0010: return ones >> 2;
            4'b0001: return ones >> 3;
            default: return ones;
        endcase
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic pipeline register with valid/ready handshake; holds data while stalled.
module elastic_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the payload register is reset as well, so data outputs read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/tree_hash.sv
// XOR-tree hash: folds an HIN-bit word into HOUT bits by XORing HOUT-wide chunks.
module tree_hash #(
    parameter int HIN  = 56,
    parameter int HOUT = 8
) (
    input  logic [HIN-1:0]  data_i,
    output logic [HOUT-1:0] hash_o
);

    localparam int CHUNKS = (HIN + HOUT - 1) / HOUT;

    logic [CHUNKS*HOUT-1:0] padded;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        padded          = '0;
        padded[HIN-1:0] = data_i;
        hash_o          = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            hash_o = hash_o ^ padded[c*HOUT +: HOUT];
        end
    end

endmodule

// File: rtl/hash_jitter_pipe.sv
// Jitter-hash stage: per-lane XOR-tree hash ORed into the fractional sample bits,
// carried with triangle/colour sideband through a PIPE_DEPTH elastic pipeline.
module hash_jitter_pipe #(
    parameter int SIGFIG     = rast_pkg::SIGFIG,
    parameter int RADIX      = rast_pkg::RADIX,
    parameter int VERTS      = 3,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int SAMPS      = rast_pkg::SAMPS,
    parameter int PIPE_DEPTH = 2,
    parameter int SEED_W     = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid_R14H,
    output logic                                   in_ready_R14H,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    input  logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    input  logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R14S,
    input  logic [SAMPS-1:0]                       validSamp_R14H,
    input  logic [3:0]                             subSample_RnnnnU,
    input  logic                                   jitter_en_RnnnnH,
    input  logic [SEED_W-1:0]                      seed_RnnnnU,
    output logic                                   out_valid_R16H,
    input  logic                                   out_ready_R16H,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
    output logic [COLORS-1:0][SIGFIG-1:0]          color_R16U,
    output logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R16S,
    output logic [SAMPS-1:0]                       validSamp_R16H,
    output logic                                   cfg_err_RnnnnH
);

    import rast_pkg::*;

    localparam int HIN   = 2 * (SIGFIG - 4) + SEED_W;
    localparam int HW    = RADIX - 2;
    localparam int PAY_W = VERTS*AXIS*SIGFIG + COLORS*SIGFIG + 2*SAMPS*SIGFIG + SAMPS;

    logic [HW-1:0]                      mask;
    logic [1:0][SAMPS-1:0][SIGFIG-1:0]  samp_jit;
    logic [PAY_W-1:0]                   payload;
    logic                               cfg_err_q, cfg_err_d;

    assign mask = msaa_mask(subSample_RnnnnU);

    for (genvar l = 0; l < SAMPS; l++) begin : g_lane
        logic [SIGFIG-1:0] x, y;
        logic [HIN-1:0]    hx_in, hy_in;
        logic [HW-1:0]     hx, hy;
        logic              lane_jit;

        assign x     = sample_R14S[0][l];
        assign y     = sample_R14S[1][l];
        // The y hash sees swapped coordinates and an inverted seed to decorrelate the axes.
        assign hx_in = {y[SIGFIG-1:4], x[SIGFIG-1:4], seed_RnnnnU};
        assign hy_in = {x[SIGFIG-1:4], y[SIGFIG-1:4], ~seed_RnnnnU};

        tree_hash #(.HIN(HIN), .HOUT(HW)) u_hash_x (.data_i(hx_in), .hash_o(hx));
        tree_hash #(.HIN(HIN), .HOUT(HW)) u_hash_y (.data_i(hy_in), .hash_o(hy));

        assign lane_jit       = jitter_en_RnnnnH & validSamp_R14H[l];
        assign samp_jit[0][l] = lane_jit ? (x | (SIGFIG'(hx & mask) << (RADIX - HW))) : x;
        assign samp_jit[1][l] = lane_jit ? (y | (SIGFIG'(hy & mask) << (RADIX - HW))) : y;
    end

    assign payload = {tri_R14S, color_R14U, samp_jit, validSamp_R14H};

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        logic             vin, rin, vout, rout;
        logic [PAY_W-1:0] din, dout;

        if (k == 0) begin : g_first
            assign vin = in_valid_R14H;
            assign din = payload;
        end else begin : g_next
            assign vin = g_stage[k-1].vout;
            assign din = g_stage[k-1].dout;
        end

        if (k == PIPE_DEPTH - 1) begin : g_tail
            assign rout = out_ready_R16H;
        end else begin : g_body
            assign rout = g_stage[k+1].rin;
        end

        elastic_stage #(.W(PAY_W)) u_stage (
            .clk        (clk),
            .rst_n      (rst),
            .in_valid_i (vin),
            .in_ready_o (rin),
            .in_data_i  (din),
            .out_valid_o(vout),
            .out_ready_i(rout),
            .out_data_o (dout)
        );
    end

    assign in_ready_R14H  = g_stage[0].rin;
    assign out_valid_R16H = g_stage[PIPE_DEPTH-1].vout;
    assign {tri_R16S, color_R16U, sample_R16S, validSamp_R16H} = g_stage[PIPE_DEPTH-1].dout;

    // Only an accepted beat can flag a bad MSAA select; the flag holds until reset.
    assign cfg_err_d = cfg_err_q |
                       (in_valid_R14H & in_ready_R14H & ~is_onehot4(subSample_RnnnnU));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cfg_err_q <= 1'b0;
        else      cfg_err_q <= cfg_err_d;
    end

    assign cfg_err_RnnnnH = cfg_err_q;

endmodule

// File: tb/tb_hash_jitter_pipe.sv
// Scoreboard bench for hash_jitter_pipe: randomized beats against a bit-level reference model.
module tb_hash_jitter_pipe;

    localparam int SIGFIG = 24, RADIX = 10, VERTS = 3, AXIS = 3, COLORS = 3;
    localparam int SAMPS = 4, PIPE_DEPTH = 2, SEED_W = 16;
    localparam int HIN   = 2 * (SIGFIG - 4) + SEED_W;
    localparam int HOUT  = RADIX - 2;
    localparam int TRI_W = VERTS * AXIS * SIGFIG;
    localparam int COL_W = COLORS * SIGFIG;
    localparam int SMP_W = 2 * SAMPS * SIGFIG;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready, jit_en, cfg_err;
    logic [TRI_W-1:0] tri_i, tri_o;
    logic [COL_W-1:0] col_i, col_o;
    logic [SMP_W-1:0] smp_i, smp_o;
    logic [SAMPS-1:0] vs_i, vs_o;
    logic [3:0]       sub;
    logic [SEED_W-1:0] seed;

    typedef struct {
        logic [TRI_W-1:0] tri_v;
        logic [COL_W-1:0] col;
        logic [SMP_W-1:0] smp;
        logic [SAMPS-1:0] vs;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   failed   = 0;
    int   accepted = 0;

    always #5 clk = ~clk;

    hash_jitter_pipe #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
        .SAMPS(SAMPS), .PIPE_DEPTH(PIPE_DEPTH), .SEED_W(SEED_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid_R14H   (in_valid),
        .in_ready_R14H   (in_ready),
        .tri_R14S        (tri_i),
        .color_R14U      (col_i),
        .sample_R14S     (smp_i),
        .validSamp_R14H  (vs_i),
        .subSample_RnnnnU(sub),
        .jitter_en_RnnnnH(jit_en),
        .seed_RnnnnU     (seed),
        .out_valid_R16H  (out_valid),
        .out_ready_R16H  (out_ready),
        .tri_R16S        (tri_o),
        .color_R16U      (col_o),
        .sample_R16S     (smp_o),
        .validSamp_R16H  (vs_o),
        .cfg_err_RnnnnH  (cfg_err)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every hash-input bit i lands in output bit i mod HOUT.
    function automatic logic [HOUT-1:0] ref_fold(input logic [HIN-1:0] v);
        logic [HOUT-1:0] h = '0;
        for (int i = 0; i < HIN; i++) h[i % HOUT] = h[i % HOUT] ^ v[i];
        return h;
    endfunction

    // Reference: MSAA select at position p keeps HOUT-3+p low bits; anything else keeps all.
    function automatic logic [HOUT-1:0] ref_mask(input logic [3:0] s);
        int n = 0;
        int pos = 0;
        for (int i = 0; i < 4; i++) if (s[i]) begin n++; pos = i; end
        if (n != 1) return '1;
        return HOUT'((1 << (HOUT - 3 + pos)) - 1);
    endfunction

    function automatic logic [SMP_W-1:0] ref_samples(input logic [SMP_W-1:0] s,
                                                     input logic [SAMPS-1:0] v,
                                                     input logic [3:0] ss, input logic en,
                                                     input logic [SEED_W-1:0] sd);
        logic [SMP_W-1:0]  r = s;
        logic [SIGFIG-1:0] x, y, jx, jy;
        for (int l = 0; l < SAMPS; l++) begin
            x = s[l*SIGFIG +: SIGFIG];
            y = s[(SAMPS+l)*SIGFIG +: SIGFIG];
            if (en && v[l]) begin
                jx = '0;
                jy = '0;
                jx[RADIX-1 -: HOUT] = ref_fold({y[SIGFIG-1:4], x[SIGFIG-1:4], sd}) & ref_mask(ss);
                jy[RADIX-1 -: HOUT] = ref_fold({x[SIGFIG-1:4], y[SIGFIG-1:4], ~sd}) & ref_mask(ss);
                r[l*SIGFIG +: SIGFIG]         = x | jx;
                r[(SAMPS+l)*SIGFIG +: SIGFIG] = y | jy;
            end
        end
        return r;
    endfunction

    task automatic send_beat(input logic [TRI_W-1:0] t, input logic [COL_W-1:0] c,
                             input logic [SMP_W-1:0] s, input logic [SAMPS-1:0] v,
                             input logic [3:0] ss, input logic en,
                             input logic [SEED_W-1:0] sd, input logic [SMP_W-1:0] exp_s);
        exp_t e;
        bit   done = 0;
        tri_i = t; col_i = c; smp_i = s; vs_i = v; sub = ss; jit_en = en; seed = sd;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                e.tri_v = t; e.col = c; e.smp = exp_s; e.vs = v;
                exp_q.push_back(e);
                accepted++;
                done = 1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            compared++;
            failed++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
    endtask

    task automatic send_rand(input logic [3:0] ss, input logic en);
        logic [TRI_W-1:0]  t;
        logic [COL_W-1:0]  c;
        logic [SMP_W-1:0]  s;
        logic [SAMPS-1:0]  v;
        logic [SEED_W-1:0] sd;
        for (int i = 0; i < TRI_W; i++) t[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < COL_W; i++) c[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < SMP_W; i++) s[i] = 1'($urandom_range(0, 1));
        v  = SAMPS'($urandom);
        sd = SEED_W'($urandom);
        send_beat(t, c, s, v, ss, en, sd, ref_samples(s, v, ss, en, sd));
    endtask

    function automatic logic [3:0] rand_onehot();
        return 4'b0001 << $urandom_range(0, 3);
    endfunction

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            failed++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
        repeat (2) tick();
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    initial begin
        bit               stalled = 0;
        logic [511:0]     held = '0;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("stall_valid", 512'(out_valid), 512'(1));
                    check("stall_data", 512'({tri_o, col_o, smp_o, vs_o}), held);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        failed++;
                        $display("FAIL unexpected_out: got beat vs=%0h, expected no beat", vs_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_samples", 512'(smp_o), 512'(e.smp));
                        check("out_tri", 512'(tri_o), 512'(e.tri_v));
                        check("out_color", 512'(col_o), 512'(e.col));
                        check("out_vs", 512'(vs_o), 512'(e.vs));
                    end
                end
                stalled = out_valid && !out_ready;
                held    = 512'({tri_o, col_o, smp_o, vs_o});
            end
        end
    end

    initial begin
        int                base;
        logic [SMP_W-1:0]  s, es;
        logic [TRI_W-1:0]  t;
        logic [COL_W-1:0]  c;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; jit_en = 1'b0;
        tri_i = '0; col_i = '0; smp_i = '0; vs_i = '0; sub = 4'b1000; seed = '0;

        // 1: reset holds everything idle even while in_valid toggles
        for (int i = 0; i < 4; i++) begin
            in_valid = ~in_valid;
            tick();
            check("rst_out_valid", 512'(out_valid), 512'(0));
            check("rst_cfg_err", 512'(cfg_err), 512'(0));
            check("rst_samples", 512'(smp_o), 512'(0));
            check("rst_vs", 512'(vs_o), 512'(0));
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("post_rst_in_ready", 512'(in_ready), 512'(1));
        check("post_rst_out_valid", 512'(out_valid), 512'(0));

        // 2: streaming pass-through, then a single-beat latency probe
        for (int i = 0; i < 10; i++) send_rand(4'b1000, 1'b0);
        drain();
        send_rand(4'b1000, 1'b0);
        for (int k = 0; k < PIPE_DEPTH - 1; k++) begin
            check("latency_early", 512'(out_valid), 512'(0));
            tick();
        end
        check("latency_arrive", 512'(out_valid), 512'(1));
        drain();

        // 3: directed jitter values worked out by hand for mask 8'h7F
        for (int i = 0; i < TRI_W; i++) t[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < COL_W; i++) c[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < SMP_W; i++) s[i] = 1'($urandom_range(0, 1));
        s[0 +: SIGFIG]           = 24'h000400;
        s[SAMPS*SIGFIG +: SIGFIG] = 24'h000C00;
        es = s;
        es[0 +: SIGFIG]           = 24'h0005A8;
        es[SAMPS*SIGFIG +: SIGFIG] = 24'h000D88;
        send_beat(t, c, s, 4'b0001, 4'b0100, 1'b1, 16'h1234, es);
        send_beat(t, c, s, 4'b0001, 4'b0100, 1'b0, 16'h1234, s);
        send_beat(t, c, s, 4'b0000, 4'b0100, 1'b1, 16'h1234, s);
        for (int i = 0; i < 12; i++) send_rand(rand_onehot(), 1'b1);
        drain();

        // 4: hold out_ready low for 5 cycles in the middle of a stream
        out_ready = 1'b0;
        base = accepted;
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand(rand_onehot(), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (5) tick();
                check("bp_accepted", 512'(accepted - base), 512'(PIPE_DEPTH));
                check("bp_in_ready", 512'(in_ready), 512'(0));
                check("bp_out_valid", 512'(out_valid), 512'(1));
                out_ready = 1'b1;
            end
        join
        drain();

        fork
            begin
                for (int i = 0; i < 40; i++) send_rand(rand_onehot(), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (80) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // 5: an illegal MSAA select widens the mask and latches the error flag
        check("cfg_err_clean", 512'(cfg_err), 512'(0));
        send_rand(4'b0110, 1'b1);
        send_rand(4'b0110, 1'b1);
        send_rand(4'b0000, 1'b1);
        drain();
        check("cfg_err_set", 512'(cfg_err), 512'(1));
        send_rand(4'b1000, 1'b1);
        send_rand(4'b0001, 1'b1);
        drain();
        check("cfg_err_sticky", 512'(cfg_err), 512'(1));

        // 6: reset with two beats in flight; nothing stale may emerge afterwards
        out_ready = 1'b0;
        send_rand(rand_onehot(), 1'b1);
        send_rand(rand_onehot(), 1'b1);
        check("inflight_out_valid", 512'(out_valid), 512'(1));
        #2;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 512'(out_valid), 512'(0));
        check("midrst_samples", 512'(smp_o), 512'(0));
        check("midrst_tri", 512'(tri_o), 512'(0));
        check("midrst_cfg_err", 512'(cfg_err), 512'(0));
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            tick();
            check("post_midrst_idle", 512'(out_valid), 512'(0));
        end
        for (int i = 0; i < 3; i++) send_rand(rand_onehot(), 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
